bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Round-robin arbiter with a three-phase (idle/address/data) bus sequencer. It sits between NUM_MASTERS master ports (the `master_ug`-style traffic sources) and a single slave port (`slaver_ug`). It captures one winning request, replays it to the slave as an address phase followed by a data phase, and returns completion and read data to the winning master. Master and slave signal groups follow the `bus_if` field set: valid, addr, write_data, read_data, write, ready.

## Interface
- NUM_MASTERS, 2, number of requesting masters (1..8)
- ADDR_W, 4, address width
- DATA_W, 5, write/read data width
- One clock; reset is asynchronous and active-low.
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- m_valid  in  NUM_MASTERS  per-master request
- m_addr  in  NUM_MASTERS*ADDR_W  packed per-master address
- m_wdata  in  NUM_MASTERS*DATA_W  packed per-master write data
- m_write  in  NUM_MASTERS  1 = write, 0 = read
- m_ready  out  NUM_MASTERS  one-cycle completion pulse to the granted master
- m_rdata  out  DATA_W  read data, valid while m_ready is high
- s_valid  out  1  slave request valid
- s_phase  out  1  0 = address phase, 1 = data phase
- s_addr  out  ADDR_W  latched address
- s_wdata  out  DATA_W  latched write data
- s_write  out  1  latched direction
- s_ready  in  1  slave accepts the current phase
- s_rdata  in  DATA_W  slave read data, sampled on data-phase accept
- grant  out  NUM_MASTERS  one-hot current owner, 0 when idle
- busy  out  1  high in ADDR_PHASE and DATA_PHASE

## Operation
- FSM states: IDLE, ADDR_PHASE, DATA_PHASE.
- **IDLE**
  - The eligible set is m_valid with any master whose m_ready is currently high masked off.
  - If the eligible set is non-empty, pick the first eligible master at or after rr_ptr, wrapping around.
  - Latch that master's addr, wdata and write; set grant; go to ADDR_PHASE.
- **ADDR_PHASE**
  - s_valid=1, s_phase=0.
  - If s_ready is high, go to DATA_PHASE; otherwise hold.
- **DATA_PHASE**
  - s_valid=1, s_phase=1.
  - If s_ready is high:
    - m_rdata <= s_rdata;
    - m_ready[winner] <= 1 for exactly one cycle;
    - rr_ptr <= (winner+1) mod NUM_MASTERS;
    - grant <= 0;
    - go to IDLE.
- Payload is latched at grant time, so changes on the m_* inputs during a transaction are ignored.
- A master that drops m_valid mid-transaction does not abort the transaction; it completes normally.
- s_addr, s_wdata and s_write hold their last latched values while idle.
- m_rdata is updated on every completion, including writes.
- No timeout: the FSM waits on s_ready indefinitely.

## Timing
- All outputs are registered.
- Reset values: state=IDLE, rr_ptr=0, and s_valid, s_phase, s_addr, s_wdata, s_write, m_ready, m_rdata, grant, busy all 0.
- Asynchronous reset mid-transaction returns to IDLE immediately, with no m_ready pulse.
- Latency:
  - Request sampled at edge E: s_valid=1 with s_phase=0 from E.
  - With s_ready held high, s_phase=1 from E+1.
  - m_ready is high in the cycle after E+2.
  - Minimum 3 cycles per transaction, plus one cycle back in IDLE.
- Back-to-back operation: the next grant is taken in the IDLE cycle carrying m_ready. The completing master is excluded from that grant, so a master holding valid for one edge after m_ready is not re-served.
- Simultaneous requests: rr_ptr decides. After serving master k, master k has the lowest priority.
- NUM_MASTERS=1: the single master is served, with a mandatory idle cycle between its transactions.

## Structure
- Package bus_pkg holds:
  - ADDR_W and DATA_W defaults;
  - the state enum (IDLE, ADDR_PHASE, DATA_PHASE);
  - the phase encoding constants PH_ADDR=0 and PH_DATA=1.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req[NUM_MASTERS] and ptr.
  - Outputs: one-hot gnt and index.
- bus_arbiter contains the FSM, payload registers and output registers.

## Test plan
- Reset: hold reset_n=0 with m_valid=2'b11 -> all outputs 0. Assert reset_n low mid-DATA_PHASE -> s_valid=0 immediately and no m_ready pulse.
- Single write: master0 with addr=4'b1011, wdata=5'b11010, write=1, s_ready=1 -> s_phase 0 then 1 with s_addr=1011 and s_wdata=11010, m_ready=2'b01 pulses for one cycle.
- Slave stall: s_ready=0 for 3 cycles in each phase -> each phase holds and s_valid stays 1; completion follows after s_ready rises.
- Fairness: both masters request continuously -> grant sequence 01, 10, 01, 10. Each m_ready pulse lands on the correct master.
- Read: master1 with write=0 and s_rdata=5'b00111 on data accept -> m_rdata=00111 while m_ready=2'b10.
- Re-request masking: master0 holds m_valid one edge past m_ready, master1 is idle -> no new grant to master0 in the m_ready cycle; master0 is re-granted the following cycle if it is still requesting.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared bus definitions for the arbiter: default widths, sequencer states and
// the slave phase encoding.
package bus_pkg;

    localparam int BUS_ADDR_W = 4;
    localparam int BUS_DATA_W = 5;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ADDR_PHASE = 2'd1,
        DATA_PHASE = 2'd2
    } bus_state_e;

    localparam logic PH_ADDR = 1'b0;
    localparam logic PH_DATA = 1'b1;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping to index 0, returned both one-hot and as an index.
module rr_pick #(
    parameter int NUM_MASTERS = 2,
    parameter int PTR_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [PTR_W-1:0]       ptr,
    output logic [NUM_MASTERS-1:0] gnt,
    output logic [PTR_W-1:0]       index
);

    logic found_s;
    logic hit_s;

    // Two passes: upper segment from ptr first, then the wrapped lower segment.
    always_comb begin
        gnt     = '0;
        index   = '0;
        found_s = 1'b0;
        hit_s   = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            hit_s   = !found_s && req[k] && (k >= int'(ptr));
            gnt[k]  = gnt[k] | hit_s;
            index   = hit_s ? PTR_W'(k) : index;
            found_s = found_s | hit_s;
        end
        for (int k = 0; k < NUM_MASTERS; k++) begin
            hit_s   = !found_s && req[k] && (k < int'(ptr));
            gnt[k]  = gnt[k] | hit_s;
            index   = hit_s ? PTR_W'(k) : index;
            found_s = found_s | hit_s;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: grants one master, replays its request to the slave
// as an address phase then a data phase, and returns completion and read data.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = bus_pkg::BUS_ADDR_W,
    parameter int DATA_W      = bus_pkg::BUS_DATA_W
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_MASTERS-1:0]        m_valid,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
    input  logic [NUM_MASTERS-1:0]        m_write,
    output logic [NUM_MASTERS-1:0]        m_ready,
    output logic [DATA_W-1:0]             m_rdata,
    output logic                          s_valid,
    output logic                          s_phase,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [DATA_W-1:0]             s_wdata,
    output logic                          s_write,
    input  logic                          s_ready,
    input  logic [DATA_W-1:0]             s_rdata,
    output logic [NUM_MASTERS-1:0]        grant,
    output logic                          busy
);

    localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    bus_state_e               state_r, state_s;
    logic [PTR_W-1:0]         rr_ptr_r, rr_ptr_s;
    logic [PTR_W-1:0]         win_idx_r, win_idx_s;
    logic [NUM_MASTERS-1:0]   grant_r, grant_s;
    logic [NUM_MASTERS-1:0]   m_ready_r, m_ready_s;
    logic [DATA_W-1:0]        m_rdata_r, m_rdata_s;
    logic                     s_valid_r, s_valid_s;
    logic                     s_phase_r, s_phase_s;
    logic [ADDR_W-1:0]        s_addr_r, s_addr_s;
    logic [DATA_W-1:0]        s_wdata_r, s_wdata_s;
    logic                     s_write_r, s_write_s;
    logic                     busy_r, busy_s;

    logic [NUM_MASTERS-1:0]   pick_gnt_s;
    logic [PTR_W-1:0]         pick_idx_s;
    logic [ADDR_W-1:0]        addr_sel_s;
    logic [DATA_W-1:0]        wdata_sel_s;
    logic                     write_sel_s;

    // A master still showing its completion pulse is not eligible this cycle.
    rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .PTR_W       (PTR_W)
    ) u_pick (
        .req   (m_valid & ~m_ready_r),
        .ptr   (rr_ptr_r),
        .gnt   (pick_gnt_s),
        .index (pick_idx_s)
    );

    // One-hot AND-OR mux of the picked master's payload.
    always_comb begin
        addr_sel_s  = '0;
        wdata_sel_s = '0;
        write_sel_s = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            addr_sel_s  = addr_sel_s  | ({ADDR_W{pick_gnt_s[i]}} & m_addr[i*ADDR_W +: ADDR_W]);
            wdata_sel_s = wdata_sel_s | ({DATA_W{pick_gnt_s[i]}} & m_wdata[i*DATA_W +: DATA_W]);
            write_sel_s = write_sel_s | (pick_gnt_s[i] & m_write[i]);
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_s   = state_r;
        rr_ptr_s  = rr_ptr_r;
        win_idx_s = win_idx_r;
        grant_s   = grant_r;
        m_ready_s = '0;
        m_rdata_s = m_rdata_r;
        s_valid_s = s_valid_r;
        s_phase_s = s_phase_r;
        s_addr_s  = s_addr_r;
        s_wdata_s = s_wdata_r;
        s_write_s = s_write_r;
        busy_s    = busy_r;
        case (state_r)
            IDLE: begin
                if (|pick_gnt_s) begin
                    state_s   = ADDR_PHASE;
                    grant_s   = pick_gnt_s;
                    win_idx_s = pick_idx_s;
                    s_addr_s  = addr_sel_s;
                    s_wdata_s = wdata_sel_s;
                    s_write_s = write_sel_s;
                    s_valid_s = 1'b1;
                    s_phase_s = PH_ADDR;
                    busy_s    = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            ADDR_PHASE: begin
                if (s_ready) begin
                    state_s   = DATA_PHASE;
                    s_phase_s = PH_DATA;
                end else begin
                    state_s = ADDR_PHASE;
                end
            end
            DATA_PHASE: begin
                if (s_ready) begin
                    state_s   = IDLE;
                    m_rdata_s = s_rdata;
                    m_ready_s = grant_r;
                    rr_ptr_s  = (win_idx_r == PTR_W'(NUM_MASTERS - 1)) ? '0 : win_idx_r + PTR_W'(1);
                    grant_s   = '0;
                    s_valid_s = 1'b0;
                    s_phase_s = PH_ADDR;
                    busy_s    = 1'b0;
                end else begin
                    state_s = DATA_PHASE;
                end
            end
            default: begin
                state_s   = IDLE;
                grant_s   = '0;
                s_valid_s = 1'b0;
                s_phase_s = PH_ADDR;
                busy_s    = 1'b0;
            end
        endcase
    end

    // State, pointer, payload and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            rr_ptr_r  <= '0;
            win_idx_r <= '0;
            grant_r   <= '0;
            m_ready_r <= '0;
            m_rdata_r <= '0;
            s_valid_r <= 1'b0;
            s_phase_r <= PH_ADDR;
            s_addr_r  <= '0;
            s_wdata_r <= '0;
            s_write_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            rr_ptr_r  <= rr_ptr_s;
            win_idx_r <= win_idx_s;
            grant_r   <= grant_s;
            m_ready_r <= m_ready_s;
            m_rdata_r <= m_rdata_s;
            s_valid_r <= s_valid_s;
            s_phase_r <= s_phase_s;
            s_addr_r  <= s_addr_s;
            s_wdata_r <= s_wdata_s;
            s_write_r <= s_write_s;
            busy_r    <= busy_s;
        end
    end

    assign m_ready = m_ready_r;
    assign m_rdata = m_rdata_r;
    assign s_valid = s_valid_r;
    assign s_phase = s_phase_r;
    assign s_addr  = s_addr_r;
    assign s_wdata = s_wdata_r;
    assign s_write = s_write_r;
    assign grant   = grant_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with two masters: reset, write, read, stall,
// fairness, re-request masking and asynchronous reset during a data phase.
module tb_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] m_valid;
    logic [7:0] m_addr;
    logic [9:0] m_wdata;
    logic [1:0] m_write;
    logic [1:0] m_ready;
    logic [4:0] m_rdata;
    logic       s_valid;
    logic       s_phase;
    logic [3:0] s_addr;
    logic [4:0] s_wdata;
    logic       s_write;
    logic       s_ready;
    logic [4:0] s_rdata;
    logic [1:0] grant;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    bus_arbiter #(.NUM_MASTERS(2), .ADDR_W(4), .DATA_W(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .m_valid (m_valid),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_write (m_write),
        .m_ready (m_ready),
        .m_rdata (m_rdata),
        .s_valid (s_valid),
        .s_phase (s_phase),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_write (s_write),
        .s_ready (s_ready),
        .s_rdata (s_rdata),
        .grant   (grant),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b1;
        m_valid = 2'b00;
        m_addr  = 8'h00;
        m_wdata = 10'h000;
        m_write = 2'b00;
        s_ready = 1'b0;
        s_rdata = 5'b00000;
        #2;
        reset_n = 1'b0;
        m_valid = 2'b11;
        s_ready = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if ({s_valid, s_phase, s_addr, s_wdata, s_write, m_ready, m_rdata, grant, busy} !== 22'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0", {s_valid, s_phase, s_addr, s_wdata, s_write, m_ready, m_rdata, grant, busy});
        end
        m_valid = 2'b00;
        reset_n = 1'b1;
        tick();
        checks++;
        if ({s_valid, grant, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_release got=%b exp=0000", {s_valid, grant, busy});
        end
    endtask

    task automatic test_single_write;
        s_ready = 1'b1;
        m_addr  = {4'b0000, 4'b1011};
        m_wdata = {5'b00000, 5'b11010};
        m_write = 2'b01;
        m_valid = 2'b01;
        tick();
        checks++;
        if ({s_valid, s_phase, s_addr, s_wdata, s_write, grant, busy} !== {1'b1, 1'b0, 4'b1011, 5'b11010, 1'b1, 2'b01, 1'b1}) begin
            failures++;
            $display("FAIL write_addr_phase got=%b", {s_valid, s_phase, s_addr, s_wdata, s_write, grant, busy});
        end
        m_valid = 2'b00;
        m_addr  = 8'hFF;
        tick();
        checks++;
        if ({s_valid, s_phase, s_addr, m_ready} !== {1'b1, 1'b1, 4'b1011, 2'b00}) begin
            failures++;
            $display("FAIL write_data_phase got=%b exp=%b", {s_valid, s_phase, s_addr, m_ready}, {1'b1, 1'b1, 4'b1011, 2'b00});
        end
        tick();
        checks++;
        if ({m_ready, grant, s_valid, busy} !== {2'b01, 2'b00, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL write_complete got=%b exp=010000", {m_ready, grant, s_valid, busy});
        end
        tick();
        checks++;
        if ({m_ready, s_addr, s_wdata} !== {2'b00, 4'b1011, 5'b11010}) begin
            failures++;
            $display("FAIL write_pulse_end got=%b", {m_ready, s_addr, s_wdata});
        end
    endtask

    task automatic test_read;
        s_ready = 1'b1;
        m_addr  = {4'b0110, 4'b0000};
        m_wdata = {5'b10001, 5'b00000};
        m_write = 2'b01;
        s_rdata = 5'b00111;
        m_valid = 2'b10;
        tick();
        checks++;
        if ({grant, s_addr, s_write, s_phase} !== {2'b10, 4'b0110, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL read_grant got=%b", {grant, s_addr, s_write, s_phase});
        end
        m_valid = 2'b00;
        tick();
        tick();
        checks++;
        if ({m_ready, m_rdata} !== {2'b10, 5'b00111}) begin
            failures++;
            $display("FAIL read_data got=%b exp=%b", {m_ready, m_rdata}, {2'b10, 5'b00111});
        end
        s_rdata = 5'b00000;
        tick();
        checks++;
        if (m_ready !== 2'b00) begin
            failures++;
            $display("FAIL read_pulse_end got=%b exp=00", m_ready);
        end
    endtask

    task automatic test_fairness;
        logic [1:0] exp_g;
        s_ready = 1'b1;
        m_write = 2'b11;
        m_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            checks++;
            if ({grant, s_valid, s_phase} !== {exp_g, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL fair_grant%0d got=%b exp=%b", k, {grant, s_valid, s_phase}, {exp_g, 2'b10});
            end
            tick();
            tick();
            checks++;
            if ({m_ready, grant} !== {exp_g, 2'b00}) begin
                failures++;
                $display("FAIL fair_ready%0d got=%b exp=%b", k, {m_ready, grant}, {exp_g, 2'b00});
            end
        end
        m_valid = 2'b00;
        tick();
        checks++;
        if ({grant, busy} !== 3'b000) begin
            failures++;
            $display("FAIL fair_idle got=%b exp=000", {grant, busy});
        end
    endtask

    task automatic test_stall;
        s_ready = 1'b0;
        m_addr  = {4'b0000, 4'b0011};
        m_wdata = {5'b00000, 5'b10101};
        m_write = 2'b01;
        m_valid = 2'b01;
        tick();
        m_valid = 2'b00;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({s_valid, s_phase, grant} !== {1'b1, 1'b0, 2'b01}) begin
                failures++;
                $display("FAIL stall_addr%0d got=%b exp=1001", k, {s_valid, s_phase, grant});
            end
        end
        s_ready = 1'b1;
        tick();
        s_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({s_valid, s_phase, m_ready, s_addr} !== {1'b1, 1'b1, 2'b00, 4'b0011}) begin
                failures++;
                $display("FAIL stall_data%0d got=%b", k, {s_valid, s_phase, m_ready, s_addr});
            end
        end
        s_ready = 1'b1;
        tick();
        checks++;
        if ({m_ready, s_valid} !== {2'b01, 1'b0}) begin
            failures++;
            $display("FAIL stall_complete got=%b exp=010", {m_ready, s_valid});
        end
        tick();
    endtask

    task automatic test_back_to_back_mask;
        s_ready = 1'b1;
        m_write = 2'b00;
        m_valid = 2'b01;
        tick();
        tick();
        tick();
        checks++;
        if (m_ready !== 2'b01) begin
            failures++;
            $display("FAIL mask_ready got=%b exp=01", m_ready);
        end
        tick();
        checks++;
        if ({grant, s_valid, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL mask_no_regrant got=%b exp=0000", {grant, s_valid, busy});
        end
        tick();
        checks++;
        if ({grant, s_valid, s_phase} !== {2'b01, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL mask_regrant got=%b exp=0110", {grant, s_valid, s_phase});
        end
        m_valid = 2'b00;
        tick();
        tick();
        checks++;
        if (m_ready !== 2'b01) begin
            failures++;
            $display("FAIL mask_second_ready got=%b exp=01", m_ready);
        end
        tick();
    endtask

    task automatic test_reset_mid_data;
        logic [1:0] seen_ready;
        s_ready = 1'b1;
        m_valid = 2'b10;
        tick();
        m_valid = 2'b00;
        tick();
        s_ready = 1'b0;
        checks++;
        if ({s_valid, s_phase, grant} !== {1'b1, 1'b1, 2'b10}) begin
            failures++;
            $display("FAIL mid_in_data got=%b exp=1110", {s_valid, s_phase, grant});
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({s_valid, s_phase, grant, busy, m_ready} !== 7'd0) begin
            failures++;
            $display("FAIL mid_async_reset got=%b exp=0", {s_valid, s_phase, grant, busy, m_ready});
        end
        s_ready = 1'b1;
        seen_ready = 2'b00;
        tick();
        seen_ready = seen_ready | m_ready;
        reset_n = 1'b1;
        tick();
        seen_ready = seen_ready | m_ready;
        tick();
        seen_ready = seen_ready | m_ready;
        checks++;
        if ({seen_ready, s_valid, grant} !== 5'b00000) begin
            failures++;
            $display("FAIL mid_no_ready got=%b exp=00000", {seen_ready, s_valid, grant});
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read();
        test_fairness();
        test_stall();
        test_back_to_back_mask();
        test_reset_mid_data();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
